simd_ld_stream_vmem_writer: RTL and testbench

Consumes the 512-bit AXI4-Stream read beats produced by the SIMD DDR memory-interface read path (rd_tvalid/rd_tready/rd_tdata/rd_tlast) and writes them into the banked SIMD vector memory (VMEM). It packs consecutive beats into one full VMEM row spanning all banks and issues one row write per completed row, with an incrementing, wrapping row address. It also flushes a masked partial final row and signals completion to the SIMD load controller. It sits directly downstream of the read master, between the DDR interface and VMEM.

---
 rtl/simd_ld_stream_vmem_writer.sv | 150 +++++++++++++++
 tb/tb_simd_ld_stream_vmem_writer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_ld_stream_vmem_writer.sv
// Packs 512-bit read-stream beats into full VMEM rows (all banks) and issues one
// row write per row; flushes a masked partial last row and pulses done.
module simd_ld_stream_vmem_writer #(
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int NUM_BANKS          = 64,
  parameter int SIMD_DATA_WIDTH    = 32,
  parameter int VMEM_ADDR_WIDTH    = 10,
  localparam int ROW_W          = NUM_BANKS * SIMD_DATA_WIDTH,
  localparam int BEATS_PER_ROW  = ROW_W / C_M_AXI_DATA_WIDTH,
  localparam int BANKS_PER_BEAT = NUM_BANKS / BEATS_PER_ROW
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [VMEM_ADDR_WIDTH-1:0]    base_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  num_beats,
  output logic                          busy,
  output logic                          done,
  output logic                          beat_err,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] s_tdata,
  input  logic                          s_tlast,
  output logic                          vmem_wr_en,
  output logic [VMEM_ADDR_WIDTH-1:0]    vmem_wr_addr,
  output logic [ROW_W-1:0]              vmem_wr_data,
  output logic [NUM_BANKS-1:0]          vmem_wr_bank_mask,
  input  logic                          vmem_wr_grant
);
  localparam int SLOT_W = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
  localparam int DW     = C_M_AXI_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_e;

  state_e                         state_q, state_d;
  logic [VMEM_ADDR_WIDTH-1:0]     row_addr_q, row_addr_d;
  logic [C_XFER_SIZE_WIDTH-1:0]   remaining_q, remaining_d;
  logic [SLOT_W-1:0]              slot_q, slot_d;
  logic [ROW_W-1:0]               asm_q, asm_d;
  logic                           beat_err_q, beat_err_d;
  logic                           wr_en_q, wr_en_d;
  logic [VMEM_ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;
  logic [ROW_W-1:0]               wr_data_q, wr_data_d;
  logic [NUM_BANKS-1:0]           wr_mask_q, wr_mask_d;

  logic [ROW_W-1:0]     merged;
  logic [NUM_BANKS-1:0] row_mask;
  logic                 accept, last_beat, row_full;

  // Assembly with the incoming beat dropped into the current slot; later slots
  // are still zero because the assembly clears on every row issue.
  always_comb begin
    merged = asm_q;
    for (int j = 0; j < BEATS_PER_ROW; j++)
      if (slot_q == SLOT_W'(j)) merged[j*DW +: DW] = s_tdata;
    for (int b = 0; b < NUM_BANKS; b++)
      row_mask[b] = (b < (int'(slot_q) + 1) * BANKS_PER_BEAT);
  end

  always_comb begin
    state_d     = state_q;
    row_addr_d  = row_addr_q;
    remaining_d = remaining_q;
    slot_d      = slot_q;
    asm_d       = asm_q;
    beat_err_d  = beat_err_q;
    wr_en_d     = wr_en_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_mask_d   = wr_mask_q;
    // Only a stalled (ungranted) row blocks the stream; a granted one frees the slot.
    s_tready    = (state_q == RECV) && !(wr_en_q && !vmem_wr_grant);
    accept      = s_tvalid && s_tready;
    last_beat   = (remaining_q == C_XFER_SIZE_WIDTH'(1));
    row_full    = (slot_q == SLOT_W'(BEATS_PER_ROW - 1));

    if (wr_en_q && vmem_wr_grant) wr_en_d = 1'b0;

    case (state_q)
      IDLE: if (start) begin
        beat_err_d = 1'b0;
        if (num_beats != '0) begin
          row_addr_d  = base_addr;
          remaining_d = num_beats;
          slot_d      = '0;
          asm_d       = '0;
          state_d     = RECV;
        end else begin
          state_d = DONE;
        end
      end
      RECV: if (accept) begin
        if (s_tlast != last_beat) beat_err_d = 1'b1;
        remaining_d = remaining_q - C_XFER_SIZE_WIDTH'(1);
        if (row_full || last_beat) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = row_addr_q;
          wr_data_d  = merged;
          wr_mask_d  = row_mask;
          row_addr_d = row_addr_q + VMEM_ADDR_WIDTH'(1);
          asm_d      = '0;
          slot_d     = '0;
          if (last_beat) state_d = DRAIN;
        end else begin
          asm_d  = merged;
          slot_d = slot_q + SLOT_W'(1);
        end
      end
      DRAIN: if (wr_en_q && vmem_wr_grant) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      row_addr_q  <= '0;
      remaining_q <= '0;
      slot_q      <= '0;
      asm_q       <= '0;
      beat_err_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_mask_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_addr_q  <= row_addr_d;
      remaining_q <= remaining_d;
      slot_q      <= slot_d;
      asm_q       <= asm_d;
      beat_err_q  <= beat_err_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_mask_q   <= wr_mask_d;
    end
  end

  assign busy              = (state_q != IDLE);
  assign done              = (state_q == DONE);
  assign beat_err          = beat_err_q;
  assign vmem_wr_en        = wr_en_q;
  assign vmem_wr_addr      = wr_addr_q;
  assign vmem_wr_data      = wr_data_q;
  assign vmem_wr_bank_mask = wr_mask_q;

endmodule

// File: tb/tb_simd_ld_stream_vmem_writer.sv
// Directed bench for simd_ld_stream_vmem_writer: row packing, partial flush,
// grant stalls, address wrap, tlast errors, zero-length and mid-transfer reset.
module tb_simd_ld_stream_vmem_writer;
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [9:0]    base_addr = '0;
  logic [31:0]   num_beats = '0;
  logic          busy, done, beat_err;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [511:0]  s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          vmem_wr_en;
  logic [9:0]    vmem_wr_addr;
  logic [2047:0] vmem_wr_data;
  logic [63:0]   vmem_wr_bank_mask;
  logic          vmem_wr_grant = 1'b1;

  int n_checks = 0;
  int n_err    = 0;

  simd_ld_stream_vmem_writer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .num_beats(num_beats), .busy(busy), .done(done), .beat_err(beat_err),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .vmem_wr_en(vmem_wr_en), .vmem_wr_addr(vmem_wr_addr), .vmem_wr_data(vmem_wr_data),
    .vmem_wr_bank_mask(vmem_wr_bank_mask), .vmem_wr_grant(vmem_wr_grant)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] beat(input int i);
    logic [31:0] w;
    w = i;
    return {16{w}};
  endfunction

  // Expected row: beats first..first+cnt-1 from the LSB slot upward, rest zero.
  function automatic logic [2047:0] row_exp(input int first, input int cnt);
    logic [2047:0] r;
    r = '0;
    for (int k = 0; k < cnt; k++) r[k*512 +: 512] = beat(first + k);
    return r;
  endfunction

  // Grant generator: holds grant low for the next stall_arm-stall_used ungranted cycles.
  int stall_arm  = 0;
  int stall_used = 0;
  always @(negedge clk) begin
    if (vmem_wr_en && stall_used < stall_arm) begin
      vmem_wr_grant = 1'b0;
      stall_used++;
    end else begin
      vmem_wr_grant = 1'b1;
    end
  end

  // Write / done monitor, sampled mid-cycle after the inputs have settled.
  logic [9:0]    wa_q[$];
  logic [2047:0] wd_q[$];
  logic [63:0]   wm_q[$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0, stall_cnt = 0, unstable = 0;
  logic          prev_stalled = 1'b0;
  logic [9:0]    prev_a;
  logic [2047:0] prev_d;
  logic [63:0]   prev_m;
  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (reset_n) begin
      if (prev_stalled && vmem_wr_en &&
          (vmem_wr_addr !== prev_a || vmem_wr_data !== prev_d || vmem_wr_bank_mask !== prev_m))
        unstable++;
      if (vmem_wr_en && !vmem_wr_grant && !s_tready) stall_cnt++;
      prev_stalled = vmem_wr_en && !vmem_wr_grant;
      prev_a = vmem_wr_addr; prev_d = vmem_wr_data; prev_m = vmem_wr_bank_mask;
      if (vmem_wr_en && vmem_wr_grant) begin
        wa_q.push_back(vmem_wr_addr);
        wd_q.push_back(vmem_wr_data);
        wm_q.push_back(vmem_wr_bank_mask);
        last_wr_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      prev_stalled = 1'b0;
    end
  end

  task automatic clear_mon();
    wa_q.delete(); wd_q.delete(); wm_q.delete();
    done_cnt = 0; stall_cnt = 0; unstable = 0;
  endtask

  task automatic start_xfer(input logic [9:0] base, input int nb);
    @(negedge clk);
    start = 1'b1; base_addr = base; num_beats = nb;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers beats 0..nsend-1; tlast on 1-based beat tpos (0 = never).
  task automatic send(input int nsend, input int tpos, output int bubbles);
    int i = 0;
    int budget = 0;
    bubbles = 0;
    while (i < nsend && budget < 200) begin
      @(negedge clk);
      s_tvalid = 1'b1; s_tdata = beat(i); s_tlast = (i + 1 == tpos);
      #1;
      if (s_tready) i++;
      else bubbles++;
      budget++;
    end
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    n_checks++;
    if (i != nsend) begin
      n_err++;
      $display("FAIL send_timeout: accepted %0d beats, required %0d", i, nsend);
    end
  endtask

  task automatic wait_done(input string nm);
    int budget = 0;
    while (done_cnt == 0 && budget < 100) begin
      @(negedge clk); #3; budget++;
    end
    repeat (3) @(negedge clk);
    #3;
    n_checks++;
    if (done_cnt !== 1) begin
      n_err++;
      $display("FAIL %s_done_count: got %0d pulses, required 1", nm, done_cnt);
    end
  endtask

  task automatic check_write(input string nm, input int idx, input logic [9:0] a,
                             input logic [2047:0] d, input logic [63:0] m);
    n_checks++;
    if (wa_q.size() <= idx) begin
      n_err++;
      $display("FAIL %s_w%0d_missing: got %0d writes, required > %0d", nm, idx, wa_q.size(), idx);
    end else if (wa_q[idx] !== a || wd_q[idx] !== d || wm_q[idx] !== m) begin
      n_err++;
      $display("FAIL %s_w%0d: addr %h mask %h data_lsw %h, required addr %h mask %h data_lsw %h",
               nm, idx, wa_q[idx], wm_q[idx], wd_q[idx][63:0], a, m, d[63:0]);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, got, exp);
    end
  endtask

  task automatic check_all_zero(input string nm);
    n_checks++;
    if ({busy, done, beat_err, s_tready, vmem_wr_en} !== 5'b0 || vmem_wr_addr !== '0 ||
        vmem_wr_data !== '0 || vmem_wr_bank_mask !== '0) begin
      n_err++;
      $display("FAIL %s: busy %b done %b err %b rdy %b wen %b addr %h mask %h, required all 0",
               nm, busy, done, beat_err, s_tready, vmem_wr_en, vmem_wr_addr, vmem_wr_bank_mask);
    end
  endtask

  task automatic test_reset();
    #1;
    check_all_zero("reset_outputs");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_full_rows();
    int bub;
    clear_mon();
    start_xfer(10'h010, 8);
    send(8, 8, bub);
    wait_done("full");
    check_int("full_ready_bubbles", bub, 0);
    check_int("full_write_count", wa_q.size(), 2);
    check_write("full", 0, 10'h010, row_exp(0, 4), '1);
    check_write("full", 1, 10'h011, row_exp(4, 4), '1);
    check_int("full_done_latency", done_cyc - last_wr_cyc, 1);
    check_int("full_beat_err", int'(beat_err), 0);
  endtask

  task automatic test_partial();
    int bub;
    clear_mon();
    start_xfer(10'h000, 6);
    send(6, 6, bub);
    wait_done("partial");
    check_int("partial_write_count", wa_q.size(), 2);
    check_write("partial", 0, 10'h000, row_exp(0, 4), '1);
    check_write("partial", 1, 10'h001, row_exp(4, 2), 64'h0000_0000_FFFF_FFFF);
  endtask

  task automatic test_stall();
    int bub;
    clear_mon();
    stall_arm = stall_used + 5;
    start_xfer(10'h100, 8);
    send(8, 8, bub);
    wait_done("stall");
    check_int("stall_ready_low_cycles", stall_cnt, 5);
    check_int("stall_unstable_outputs", unstable, 0);
    check_int("stall_write_count", wa_q.size(), 2);
    check_write("stall", 0, 10'h100, row_exp(0, 4), '1);
    check_write("stall", 1, 10'h101, row_exp(4, 4), '1);
  endtask

  task automatic test_wrap();
    int bub;
    clear_mon();
    start_xfer(10'h3FF, 8);
    send(8, 8, bub);
    wait_done("wrap");
    check_write("wrap", 0, 10'h3FF, row_exp(0, 4), '1);
    check_write("wrap", 1, 10'h000, row_exp(4, 4), '1);
  endtask

  task automatic test_tlast_err_and_zero();
    int bub;
    clear_mon();
    start_xfer(10'h040, 4);
    send(4, 3, bub);
    wait_done("tlast");
    check_int("tlast_beat_err", int'(beat_err), 1);
    check_int("tlast_write_count", wa_q.size(), 1);
    check_write("tlast", 0, 10'h040, row_exp(0, 4), '1);
    clear_mon();
    start_xfer(10'h050, 0);
    #1;
    check_int("zero_done_next_cycle", int'(done), 1);
    check_int("zero_clears_beat_err", int'(beat_err), 0);
    @(negedge clk);
    #1;
    check_int("zero_done_single", int'(done), 0);
    repeat (3) @(negedge clk);
    #3;
    check_int("zero_no_writes", wa_q.size(), 0);
  endtask

  task automatic test_mid_reset();
    int bub;
    clear_mon();
    start_xfer(10'h080, 8);
    send(2, 0, bub);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset_outputs");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    check_int("midreset_no_write", wa_q.size(), 0);
    start_xfer(10'h020, 4);
    send(4, 4, bub);
    wait_done("after_reset");
    check_int("after_reset_write_count", wa_q.size(), 1);
    check_write("after_reset", 0, 10'h020, row_exp(0, 4), '1);
  endtask

  initial begin
    test_reset();
    test_full_rows();
    test_partial();
    test_stall();
    test_wrap();
    test_tlast_err_and_zero();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
